// File: rtl/board_renderer_pkg.sv
// ============================================================================
// board_renderer_pkg
// Shared geometry, region encoding, colour and piece-shape tables for the
// board renderer pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package board_renderer_pkg;

  // Playfield: 10 x 20 cells of 20 px, inclusive-exclusive bounds
  localparam logic [9:0] BOARD_X0 = 10'd220;
  localparam logic [9:0] BOARD_X1 = 10'd420;
  localparam logic [9:0] BOARD_Y0 = 10'd40;
  localparam logic [9:0] BOARD_Y1 = 10'd440;
  localparam logic [9:0] CELL_PX  = 10'd20;

  // White ring hugging the playfield
  localparam logic [9:0] BORDER_W = 10'd2;
  localparam logic [9:0] RING_X0  = BOARD_X0 - BORDER_W;
  localparam logic [9:0] RING_X1  = BOARD_X1 + BORDER_W;
  localparam logic [9:0] RING_Y0  = BOARD_Y0 - BORDER_W;
  localparam logic [9:0] RING_Y1  = BOARD_Y1 + BORDER_W;

  // Preview boxes are 80 x 80 (4 x 4 cells)
  localparam logic [9:0] BOX_PX   = 10'd80;
  localparam logic [9:0] HOLD_X0  = 10'd100;
  localparam logic [9:0] HOLD_X1  = HOLD_X0 + BOX_PX;
  localparam logic [9:0] HOLD_Y0  = 10'd40;
  localparam logic [9:0] HOLD_Y1  = HOLD_Y0 + BOX_PX;
  localparam logic [9:0] NEXT_X0  = 10'd460;
  localparam logic [9:0] NEXT_X1  = NEXT_X0 + BOX_PX;
  localparam logic [9:0] NEXT_Y0  = 10'd40;
  localparam int         NEXT_PITCH = 90;
  localparam int         NUM_NEXT   = 4;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_BORDER = 12'hFFF;
  localparam logic [11:0] RGB_BG     = 12'h111;

  typedef enum logic [2:0] {
    REGION_BG     = 3'd0,
    REGION_BOARD  = 3'd1,
    REGION_BORDER = 3'd2,
    REGION_HOLD   = 3'd3,
    REGION_NEXT   = 3'd4
  } region_e;

  // Cell colour for each piece kind; kind 0 is an empty cell
  function automatic logic [11:0] kind_colour(input logic [2:0] k);
    case (k)
      3'd1:    return 12'h09D;
      3'd2:    return 12'h04F;
      3'd3:    return 12'hD90;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'h0F3;
      3'd6:    return 12'h80C;
      3'd7:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  // Spawn-orientation shape, bit (4*row + col) set where a block sits
  function automatic logic [15:0] kind_mask(input logic [2:0] k);
    case (k)
      3'd1:    return 16'h00F0;  // I
      3'd2:    return 16'h0071;  // J
      3'd3:    return 16'h0074;  // L
      3'd4:    return 16'h0660;  // O
      3'd5:    return 16'h0036;  // S
      3'd6:    return 16'h0072;  // T
      3'd7:    return 16'h0063;  // Z
      default: return 16'h0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_renderer_preview_cell.sv
// ============================================================================
// board_renderer_preview_cell
// Maps a local offset inside an 80x80 preview box plus a piece kind to a
// lit flag and the kind's colour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module board_renderer_preview_cell
  import board_renderer_pkg::*;
(
  input  logic [6:0]  local_x,
  input  logic [6:0]  local_y,
  input  logic [2:0]  kind,
  output logic        lit,
  output logic [11:0] colour
);

  logic [1:0]  col;
  logic [1:0]  row;
  logic [15:0] mask;

  // Pick the 20 px cell and test its bit in the kind's shape
  always_comb begin
    col    = 2'(local_x / 7'd20);
    row    = 2'(local_y / 7'd20);
    mask   = kind_mask(kind);
    lit    = mask[{row, col}];
    colour = kind_colour(kind);
  end

endmodule

`default_nettype wire

// File: rtl/board_renderer.sv
// ============================================================================
// board_renderer
// Fixed 3-cycle pixel pipeline: S0 registers inputs, S1 classifies region and
// issues the board cell query, S2 resolves preview boxes, S3 registers rgb
// using the game core's kind response. Sync/visible ride a matching chain.
// Optional: define GRID_LINES_EN to draw 12'h222 grid lines on empty cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int LAT = 3
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        visible,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [3:0]  board_x,
  output logic [4:0]  board_y,
  input  logic [2:0]  kind,
  input  logic [2:0]  hold,
  input  logic [2:0]  next0,
  input  logic [2:0]  next1,
  input  logic [2:0]  next2,
  input  logic [2:0]  next3,
  output logic [11:0] rgb,
  output logic        hs_out,
  output logic        vs_out
);

  if (LAT != 3) begin : g_lat_check
    $error("board_renderer: only LAT=3 is supported");
  end

  // Sync/visible chains: index 0 = S0 ... sync index 3 = output
  logic [3:0]  hs_d, hs_q, vs_d, vs_q;
  logic [2:0]  vis_d, vis_q;
  // S0
  logic [9:0]  x_s0_d, x_s0_q, y_s0_d, y_s0_q;
  logic [2:0]  hold_s0_d, hold_s0_q;
  logic [11:0] next_s0_d, next_s0_q;
  // S1
  region_e     region_s1_d, region_s1_q;
  logic [2:0]  hold_s1_d, hold_s1_q, nextk_s1_d, nextk_s1_q;
  logic [6:0]  lx_s1_d, lx_s1_q, ly_s1_d, ly_s1_q;
  logic [3:0]  board_x_d, board_x_q;
  logic [4:0]  board_y_d, board_y_q;
  // S2
  region_e     region_s2_d, region_s2_q;
  logic [11:0] prev_s2_d, prev_s2_q;
  // S3
  logic [11:0] rgb_d, rgb_q;
`ifdef GRID_LINES_EN
  logic        grid_s1_d, grid_s1_q, grid_s2_d, grid_s2_q;
`endif

  // S1 classification scratch
  logic        in_board, in_ring, in_hold, in_next_x, nxt_hit;
  logic [1:0]  nxt_sel;
  logic [9:0]  nxt_y0, box_y0, bx_off, by_off;
  // Preview lookups
  logic        hold_lit, next_lit;
  logic [11:0] hold_colour, next_colour;

  // S0 capture and sync/visible chain shift
  always_comb begin
    x_s0_d    = pixel_x;
    y_s0_d    = pixel_y;
    hold_s0_d = hold;
    next_s0_d = {next3, next2, next1, next0};
    hs_d      = {hs_q[2:0], hs_in};
    vs_d      = {vs_q[2:0], vs_in};
    vis_d     = {vis_q[1:0], visible};
  end

  // S1: region classification, board query and preview-local offsets
  always_comb begin
    in_board  = (x_s0_q >= BOARD_X0) && (x_s0_q < BOARD_X1) &&
                (y_s0_q >= BOARD_Y0) && (y_s0_q < BOARD_Y1);
    in_ring   = (x_s0_q >= RING_X0) && (x_s0_q < RING_X1) &&
                (y_s0_q >= RING_Y0) && (y_s0_q < RING_Y1) && !in_board;
    in_hold   = (x_s0_q >= HOLD_X0) && (x_s0_q < HOLD_X1) &&
                (y_s0_q >= HOLD_Y0) && (y_s0_q < HOLD_Y1);
    in_next_x = (x_s0_q >= NEXT_X0) && (x_s0_q < NEXT_X1);
    nxt_hit   = 1'b0;
    nxt_sel   = 2'd0;
    nxt_y0    = NEXT_Y0;
    box_y0    = NEXT_Y0;
    for (int i = 0; i < NUM_NEXT; i++) begin
      box_y0 = NEXT_Y0 + 10'(NEXT_PITCH * i);
      if (!nxt_hit && in_next_x && (y_s0_q >= box_y0) && (y_s0_q < box_y0 + BOX_PX)) begin
        nxt_hit = 1'b1;
        nxt_sel = 2'(i);
        nxt_y0  = box_y0;
      end
    end
    // Offsets are formed only once the compare has passed, so no wrap leaks out
    bx_off    = in_board ? (x_s0_q - BOARD_X0) : 10'd0;
    by_off    = in_board ? (y_s0_q - BOARD_Y0) : 10'd0;
    board_x_d = in_board ? 4'(bx_off / CELL_PX) : board_x_q;
    board_y_d = in_board ? 5'(by_off / CELL_PX) : board_y_q;
`ifdef GRID_LINES_EN
    grid_s1_d = in_board && (((bx_off % CELL_PX) == 10'd0) || ((by_off % CELL_PX) == 10'd0));
`endif
    hold_s1_d  = hold_s0_q;
    nextk_s1_d = next_s0_q[3*nxt_sel +: 3];
    lx_s1_d    = 7'd0;
    ly_s1_d    = 7'd0;
    if (in_board) begin
      region_s1_d = REGION_BOARD;
    end else if (in_ring) begin
      region_s1_d = REGION_BORDER;
    end else if (in_hold) begin
      region_s1_d = REGION_HOLD;
      lx_s1_d     = 7'(x_s0_q - HOLD_X0);
      ly_s1_d     = 7'(y_s0_q - HOLD_Y0);
    end else if (nxt_hit) begin
      region_s1_d = REGION_NEXT;
      lx_s1_d     = 7'(x_s0_q - NEXT_X0);
      ly_s1_d     = 7'(y_s0_q - nxt_y0);
    end else begin
      region_s1_d = REGION_BG;
    end
  end

  board_renderer_preview_cell u_hold_preview (
    .local_x (lx_s1_q),
    .local_y (ly_s1_q),
    .kind    (hold_s1_q),
    .lit     (hold_lit),
    .colour  (hold_colour)
  );

  board_renderer_preview_cell u_next_preview (
    .local_x (lx_s1_q),
    .local_y (ly_s1_q),
    .kind    (nextk_s1_q),
    .lit     (next_lit),
    .colour  (next_colour)
  );

  // S2: settle preview colour so S3 only has to merge in the board kind
  always_comb begin
    region_s2_d = region_s1_q;
    if (region_s1_q == REGION_HOLD) begin
      prev_s2_d = hold_lit ? hold_colour : RGB_BLACK;
    end else begin
      prev_s2_d = next_lit ? next_colour : RGB_BLACK;
    end
`ifdef GRID_LINES_EN
    grid_s2_d = grid_s1_q;
`endif
  end

  // S3: final colour; kind arrives now for the query issued in S1
  always_comb begin
    rgb_d = RGB_BLACK;
    if (vis_q[2]) begin
      case (region_s2_q)
        REGION_BOARD: begin
          if (kind != 3'd0) begin
            rgb_d = kind_colour(kind);
          end else begin
`ifdef GRID_LINES_EN
            rgb_d = grid_s2_q ? 12'h222 : RGB_BLACK;
`else
            rgb_d = RGB_BLACK;
`endif
          end
        end
        REGION_BORDER: rgb_d = RGB_BORDER;
        REGION_HOLD,
        REGION_NEXT:   rgb_d = prev_s2_q;
        default:       rgb_d = RGB_BG;
      endcase
    end
  end

  // Pipeline registers; reset drops in-flight pixels and parks sync inactive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= '1;
      vs_q        <= '1;
      vis_q       <= '0;
      x_s0_q      <= '0;
      y_s0_q      <= '0;
      hold_s0_q   <= '0;
      next_s0_q   <= '0;
      region_s1_q <= REGION_BG;
      hold_s1_q   <= '0;
      nextk_s1_q  <= '0;
      lx_s1_q     <= '0;
      ly_s1_q     <= '0;
      board_x_q   <= '0;
      board_y_q   <= '0;
      region_s2_q <= REGION_BG;
      prev_s2_q   <= '0;
      rgb_q       <= '0;
`ifdef GRID_LINES_EN
      grid_s1_q   <= 1'b0;
      grid_s2_q   <= 1'b0;
`endif
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vis_q       <= vis_d;
      x_s0_q      <= x_s0_d;
      y_s0_q      <= y_s0_d;
      hold_s0_q   <= hold_s0_d;
      next_s0_q   <= next_s0_d;
      region_s1_q <= region_s1_d;
      hold_s1_q   <= hold_s1_d;
      nextk_s1_q  <= nextk_s1_d;
      lx_s1_q     <= lx_s1_d;
      ly_s1_q     <= ly_s1_d;
      board_x_q   <= board_x_d;
      board_y_q   <= board_y_d;
      region_s2_q <= region_s2_d;
      prev_s2_q   <= prev_s2_d;
      rgb_q       <= rgb_d;
`ifdef GRID_LINES_EN
      grid_s1_q   <= grid_s1_d;
      grid_s2_q   <= grid_s2_d;
`endif
    end
  end

  assign board_x = board_x_q;
  assign board_y = board_y_q;
  assign rgb     = rgb_q;
  assign hs_out  = hs_q[3];
  assign vs_out  = vs_q[3];

endmodule

`default_nettype wire

// File: tb/tb_board_renderer.sv
// ============================================================================
// tb_board_renderer
// Self-checking bench: randomized and directed pixels compared against a
// geometric reference model of the screen layout and a game-core model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_board_renderer;

  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        visible = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        hs_in = 1'b1, vs_in = 1'b1;
  logic [3:0]  board_x;
  logic [4:0]  board_y;
  logic [2:0]  kind;
  logic [2:0]  hold = '0, next0 = '0, next1 = '0, next2 = '0, next3 = '0;
  logic [11:0] rgb;
  logic        hs_out, vs_out;

  always #10 clk = ~clk;

  board_renderer #(.LAT(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .visible (visible),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .hs_in   (hs_in),
    .vs_in   (vs_in),
    .board_x (board_x),
    .board_y (board_y),
    .kind    (kind),
    .hold    (hold),
    .next0   (next0),
    .next1   (next1),
    .next2   (next2),
    .next3   (next3),
    .rgb     (rgb),
    .hs_out  (hs_out),
    .vs_out  (vs_out)
  );

  // Game core model: board contents, answered one cycle after the query
  logic [2:0] board_mem [20][10];
  logic [2:0] kind_r = 3'd0;
  assign kind = kind_r;
  always @(posedge clk)
    kind_r <= (board_y < 5'd20 && board_x < 4'd10) ? board_mem[board_y][board_x] : 3'd0;

  // Reference tables written from the layout description
  logic [11:0] col_tab [8] = '{12'h000, 12'h09D, 12'h04F, 12'hD90,
                               12'hFF0, 12'h0F3, 12'h80C, 12'hF00};
  string shp [8] = '{"................",
                     "....####........",
                     "#...###.........",
                     "..#.###.........",
                     ".....##..##.....",
                     ".##.##..........",
                     ".#..###.........",
                     "##...##........."};

  int n_vec = 0, n_err = 0, n = 0;
  int bx_last = 0, by_last = 0;

  logic [11:0] e_rgb [MAXC];
  logic        e_hs  [MAXC], e_vs [MAXC];
  bit          e_v   [MAXC];
  logic [3:0]  e_bx  [MAXC];
  logic [4:0]  e_by  [MAXC];
  bit          e_bv  [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [11:0] preview(input logic [2:0] k, input int lx, input int ly);
    int idx;
    idx = 4 * (ly / 20) + (lx / 20);
    return (shp[k][idx] == "#") ? col_tab[k] : 12'h000;
  endfunction

  function automatic logic [11:0] ref_pix(input bit v, input int x, input int y,
                                          input logic [2:0] hk, input logic [11:0] nk);
    logic [2:0] k;
    if (!v) return 12'h000;
    if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
      k = board_mem[(y - 40) / 20][(x - 220) / 20];
      if (k != 3'd0) return col_tab[k];
`ifdef GRID_LINES_EN
      if ((x - 220) % 20 == 0 || (y - 40) % 20 == 0) return 12'h222;
`endif
      return 12'h000;
    end
    if (x >= 218 && x < 422 && y >= 38 && y < 442) return 12'hFFF;
    if (x >= 100 && x < 180 && y >= 40 && y < 120) return preview(hk, x - 100, y - 40);
    for (int i = 0; i < 4; i++)
      if (x >= 460 && x < 540 && y >= 40 + 90 * i && y < 120 + 90 * i)
        return preview(nk[3*i +: 3], x - 460, y - 40 - 90 * i);
    return 12'h111;
  endfunction

  task automatic sched(input int c, input logic [11:0] r, input logic h, input logic v);
    e_rgb[c] = r; e_hs[c] = h; e_vs[c] = v; e_v[c] = 1'b1;
  endtask

  // Advance to the next falling edge and check whatever is due there
  task automatic tick();
    @(negedge clk);
    n++;
    if (e_v[n]) begin
      check_eq("rgb", rgb, e_rgb[n]);
      check_eq("hs_out", hs_out, e_hs[n]);
      check_eq("vs_out", vs_out, e_vs[n]);
    end
    if (e_bv[n]) begin
      check_eq("board_x", board_x, e_bx[n]);
      check_eq("board_y", board_y, e_by[n]);
    end
  endtask

  task automatic step(input bit v, input int x, input int y, input logic h, input logic vv,
                      input logic [2:0] hk, input logic [11:0] nk);
    tick();
    visible = v; pixel_x = 10'(x); pixel_y = 10'(y); hs_in = h; vs_in = vv;
    hold = hk; {next3, next2, next1, next0} = nk;
    if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
      bx_last = (x - 220) / 20;
      by_last = (y - 40) / 20;
    end
    sched(n + 4, ref_pix(v, x, y, hk, nk), h, vv);
    e_bx[n + 2] = 4'(bx_last); e_by[n + 2] = 5'(by_last); e_bv[n + 2] = 1'b1;
  endtask

  task automatic release_reset();
    tick();
    visible = 1'b0; pixel_x = '0; pixel_y = '0; hs_in = 1'b1; vs_in = 1'b1;
    reset_n = 1'b1;
    for (int m = 1; m <= 4; m++) sched(n + m, 12'h000, 1'b1, 1'b1);
    for (int m = 1; m <= 2; m++) begin
      e_bx[n + m] = 4'd0; e_by[n + m] = 5'd0; e_bv[n + m] = 1'b1;
    end
  endtask

  task automatic mid_reset();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_rgb", rgb, 12'h000);
    check_eq("mid_rst_hs", hs_out, 1'b1);
    check_eq("mid_rst_vs", vs_out, 1'b1);
    check_eq("mid_rst_bx", board_x, 4'd0);
    check_eq("mid_rst_by", board_y, 5'd0);
    for (int m = n + 1; m < MAXC; m++) begin e_v[m] = 1'b0; e_bv[m] = 1'b0; end
    bx_last = 0; by_last = 0;
    repeat (2) begin
      tick();
      check_eq("rst_hold_rgb", rgb, 12'h000);
      check_eq("rst_hold_hs", hs_out, 1'b1);
    end
    release_reset();
  endtask

  task automatic random_run(input int cnt);
    bit rv; int rx, ry; logic rh, rvs;
    logic [2:0] rhk; logic [11:0] rnk;
    rhk = 3'($urandom_range(0, 7)); rnk = 12'($urandom);
    for (int i = 0; i < cnt; i++) begin
      rv  = ($urandom_range(0, 9) != 0);
      rx  = $urandom_range(0, 1) ? $urandom_range(0, 639) : $urandom_range(90, 550);
      ry  = $urandom_range(0, 479);
      rh  = ($urandom_range(0, 7) != 0);
      rvs = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 4) == 0) begin
        rhk = 3'($urandom_range(0, 7));
        rnk = 12'($urandom);
      end
      step(rv, rx, ry, rh, rvs, rhk, rnk);
    end
  endtask

  initial begin
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        board_mem[r][c] = 3'($urandom_range(0, 7));
    board_mem[0][0] = 3'd3;
    board_mem[1][1] = 3'd0;
    board_mem[1][2] = 3'd5;

    // Reset state
    repeat (3) begin
      tick();
      check_eq("reset_rgb", rgb, 12'h000);
      check_eq("reset_hs", hs_out, 1'b1);
      check_eq("reset_vs", vs_out, 1'b1);
      check_eq("reset_bx", board_x, 4'd0);
      check_eq("reset_by", board_y, 5'd0);
    end
    release_reset();

    // Directed corners and preview cases
    step(1, 220, 40, 1, 1, 3'd0, 12'h000);    // kind 3 -> D90
    step(1, 419, 439, 1, 1, 3'd0, 12'h000);   // last cell 9,19
    step(1, 420, 439, 1, 1, 3'd0, 12'h000);   // border
    step(1, 421, 200, 1, 1, 3'd0, 12'h000);   // border
    step(1, 422, 200, 1, 1, 3'd0, 12'h000);   // background
    step(1, 120, 60, 1, 1, 3'd1, 12'h000);    // hold I lit -> 09D
    step(1, 120, 60, 1, 1, 3'd0, 12'h000);    // hold empty -> 000
    step(0, 300, 200, 1, 1, 3'd0, 12'h000);   // blanked
    step(1, 240, 60, 1, 1, 3'd0, 12'h000);    // empty cell on grid line
    step(1, 260, 60, 1, 1, 3'd0, 12'h000);    // kind 5 on grid line -> 0F3
    step(1, 480, 150, 1, 1, 3'd0, 12'h020);   // next1 = O, cell 1,1 -> FF0
    step(1, 217, 100, 1, 1, 3'd0, 12'h000);   // just outside ring
    for (int i = 0; i < 10; i++)              // hs/vs pulses of different widths
      step(1, 300, 300, (i < 3 || i > 5) ? 1'b1 : 1'b0, (i < 6) ? 1'b1 : 1'b0, 3'd0, 12'h000);
    repeat (4) step(0, 0, 0, 1, 1, 3'd0, 12'h000);

    random_run(700);
    mid_reset();
    step(1, 220, 40, 1, 1, 3'd0, 12'h000);
    random_run(800);
    repeat (5) step(0, 0, 0, 1, 1, 3'd0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
